// File: rtl/clk_chan_switch.sv
// Steers one shared clock-enable/reset/pin/data group to one of NCH channels.
// A channel change drains the old channel, idles everything, then arms the new one.
module clk_chan_switch #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned NPIN      = 3,
    parameter int unsigned NDAT      = 2,
    parameter int unsigned DRAIN_CYC = 2,
    parameter int unsigned GAP_CYC   = 4,
    parameter int unsigned RST_HOLD  = 3
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                src_rst_n,
    input  logic [SEL_W-1:0]    sel_req,
    input  logic [NPIN-1:0]     pin_in,
    input  logic [NDAT-1:0]     dat_in,
    output logic [NCH-1:0]      ch_clk_en,
    output logic [NCH-1:0]      ch_rst_n,
    output logic [NCH*NPIN-1:0] ch_pin,
    output logic [NCH*NDAT-1:0] ch_dat,
    output logic [SEL_W-1:0]    sel_o,
    output logic                busy,
    output logic                switch_done,
    output logic                sel_err
);

    localparam int unsigned MaxAB  = (DRAIN_CYC > GAP_CYC) ? DRAIN_CYC : GAP_CYC;
    localparam int unsigned MaxCyc = (MaxAB > RST_HOLD) ? MaxAB : RST_HOLD;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam logic [SEL_W:0] NchW = (SEL_W + 1)'(NCH);

    typedef enum logic [1:0] {StActive, StDrain, StGap, StArm} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [SEL_W-1:0] cur_sel_q;
    logic [SEL_W-1:0] tgt_sel_q;
    logic             sel_err_q;
    logic             switch_done_q;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q       <= StArm;
            cnt_q         <= CntW'(RST_HOLD);
            cur_sel_q     <= '0;
            tgt_sel_q     <= '0;
            sel_err_q     <= 1'b0;
            switch_done_q <= 1'b0;
        end else begin
            switch_done_q <= 1'b0;
            unique case (state_q)
                StActive: begin
                    if (sel_req != cur_sel_q) begin
                        if ({1'b0, sel_req} >= NchW) begin
                            sel_err_q <= 1'b1;
                        end else begin
                            tgt_sel_q <= sel_req;
                            cnt_q     <= CntW'(DRAIN_CYC);
                            state_q   <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (cnt_q == CntW'(1)) begin
                        cnt_q   <= CntW'(GAP_CYC);
                        state_q <= StGap;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StGap: begin
                    if (cnt_q == CntW'(1)) begin
                        cur_sel_q <= tgt_sel_q;
                        cnt_q     <= CntW'(RST_HOLD);
                        state_q   <= StArm;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StArm: begin
                    if (cnt_q == CntW'(1)) begin
                        switch_done_q <= 1'b1;
                        state_q       <= StActive;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
            endcase
        end
    end

    // rst gates the decode so outputs go idle the instant reset asserts.
    always_comb begin
        ch_clk_en = '0;
        ch_rst_n  = '0;
        ch_pin    = '1;
        ch_dat    = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (rst && (k == 32'(cur_sel_q))) begin
                unique case (state_q)
                    StActive: begin
                        ch_clk_en[k]              = 1'b1;
                        ch_rst_n[k]               = src_rst_n;
                        ch_pin[k*NPIN +: NPIN]    = pin_in;
                        ch_dat[k*NDAT +: NDAT]    = dat_in;
                    end
                    StDrain: begin
                        ch_rst_n[k]               = src_rst_n;
                        ch_pin[k*NPIN +: NPIN]    = pin_in;
                        ch_dat[k*NDAT +: NDAT]    = dat_in;
                    end
                    StGap: begin
                    end
                    StArm: begin
                        ch_clk_en[k] = 1'b1;
                    end
                endcase
            end
        end
    end

    assign sel_o       = cur_sel_q;
    assign busy        = (state_q != StActive);
    assign switch_done = switch_done_q;
    assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_clk_chan_switch.sv
// Directed bench for clk_chan_switch: reset/arm, timed switches, ignored
// mid-switch requests, reset mid-switch, sticky select error and enable invariants.
module tb_clk_chan_switch;

    localparam int unsigned GapCyc = 4;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        src_rst_n;
    logic [1:0]  sel_req;
    logic [1:0]  sel3;
    logic [2:0]  pin_in;
    logic [1:0]  dat_in;

    logic [3:0]  ch_clk_en, ch_rst_n;
    logic [11:0] ch_pin;
    logic [7:0]  ch_dat;
    logic [1:0]  sel_o;
    logic        busy, switch_done, sel_err;

    logic [2:0]  clk_en3, rst_n3;
    logic [8:0]  pin3;
    logic [5:0]  dat3;
    logic [1:0]  sel_o3;
    logic        busy3, done3, err3;

    int n_checks = 0;
    int n_fail   = 0;
    int viol_onehot = 0;
    int viol_gap    = 0;
    int zero_run    = 100;
    logic [3:0] last_en = '0;

    always #5 clk_in = ~clk_in;

    clk_chan_switch u_dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .src_rst_n  (src_rst_n),
        .sel_req    (sel_req),
        .pin_in     (pin_in),
        .dat_in     (dat_in),
        .ch_clk_en  (ch_clk_en),
        .ch_rst_n   (ch_rst_n),
        .ch_pin     (ch_pin),
        .ch_dat     (ch_dat),
        .sel_o      (sel_o),
        .busy       (busy),
        .switch_done(switch_done),
        .sel_err    (sel_err)
    );

    clk_chan_switch #(.NCH(3)) u_dut3 (
        .clk_in     (clk_in),
        .rst        (rst),
        .src_rst_n  (src_rst_n),
        .sel_req    (sel3),
        .pin_in     (pin_in),
        .dat_in     (dat_in),
        .ch_clk_en  (clk_en3),
        .ch_rst_n   (rst_n3),
        .ch_pin     (pin3),
        .ch_dat     (dat3),
        .sel_o      (sel_o3),
        .busy       (busy3),
        .switch_done(done3),
        .sel_err    (err3)
    );

    // Enable invariants: at most one bit set, and a different channel only after
    // at least GapCyc sampled cycles with every enable low.
    always @(negedge clk_in) begin
        if (rst) begin
            if (!$onehot0(ch_clk_en)) viol_onehot <= viol_onehot + 1;
            if (ch_clk_en == 4'b0000) begin
                zero_run <= zero_run + 1;
            end else begin
                if (last_en != 4'b0000 && ch_clk_en != last_en && zero_run < GapCyc)
                    viol_gap <= viol_gap + 1;
                last_en  <= ch_clk_en;
                zero_run <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    function automatic logic [11:0] pin_exp(input int k, input logic [2:0] p);
        logic [11:0] v;
        v = '1;
        v[k*3 +: 3] = p;
        return v;
    endfunction

    function automatic logic [7:0] dat_exp(input int k, input logic [1:0] d);
        logic [7:0] v;
        v = '0;
        v[k*2 +: 2] = d;
        return v;
    endfunction

    initial begin
        rst = 1'b1; sel_req = 2'd0; sel3 = 2'd0; src_rst_n = 1'b1;
        pin_in = 3'b101; dat_in = 2'b10;
        #1 rst = 1'b0;
        tick; tick;
        chk("rst_clk_en", 32'(ch_clk_en), 32'h0);
        chk("rst_rst_n", 32'(ch_rst_n), 32'h0);
        chk("rst_pin", 32'(ch_pin), 32'hfff);
        chk("rst_dat", 32'(ch_dat), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_done", 32'(switch_done), 32'h0);
        chk("rst_sel_o", 32'(sel_o), 32'h0);
        chk("rst_err", 32'(sel_err), 32'h0);

        rst = 1'b1; #1;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("arm%0d_clk_en", c), 32'(ch_clk_en), 32'h1);
            chk($sformatf("arm%0d_rst_n", c), 32'(ch_rst_n), 32'h0);
            chk($sformatf("arm%0d_pin", c), 32'(ch_pin), 32'hfff);
            chk($sformatf("arm%0d_busy", c), 32'(busy), 32'h1);
            tick;
        end
        chk("act0_done", 32'(switch_done), 32'h1);
        chk("act0_busy", 32'(busy), 32'h0);
        chk("act0_clk_en", 32'(ch_clk_en), 32'h1);
        chk("act0_rst_n", 32'(ch_rst_n), 32'h1);
        chk("act0_pin", 32'(ch_pin), 32'(pin_exp(0, 3'b101)));
        chk("act0_dat", 32'(ch_dat), 32'(dat_exp(0, 2'b10)));
        tick;
        chk("act0_done_pulse", 32'(switch_done), 32'h0);
        src_rst_n = 1'b0; pin_in = 3'b010; #1;
        chk("act0_src_rst", 32'(ch_rst_n), 32'h0);
        chk("act0_pin_follow", 32'(ch_pin), 32'(pin_exp(0, 3'b010)));
        src_rst_n = 1'b1;

        // Request channel 2; a request for 3 at t+4 must not retarget it.
        sel_req = 2'd2;
        tick;
        for (int c = 1; c <= 20; c++) begin
            pin_in = 3'(c); #1;
            if (c <= 2) begin
                chk($sformatf("c%0d_clk_en", c), 32'(ch_clk_en), 32'h0);
                chk($sformatf("c%0d_rst_n", c), 32'(ch_rst_n), 32'h1);
                chk($sformatf("c%0d_pin", c), 32'(ch_pin), 32'(pin_exp(0, pin_in)));
                chk($sformatf("c%0d_busy", c), 32'(busy), 32'h1);
            end else if (c <= 6) begin
                chk($sformatf("c%0d_clk_en", c), 32'(ch_clk_en), 32'h0);
                chk($sformatf("c%0d_rst_n", c), 32'(ch_rst_n), 32'h0);
                chk($sformatf("c%0d_pin", c), 32'(ch_pin), 32'hfff);
                chk($sformatf("c%0d_sel_o", c), 32'(sel_o), 32'h0);
            end else if (c <= 9) begin
                chk($sformatf("c%0d_clk_en", c), 32'(ch_clk_en), 32'h4);
                chk($sformatf("c%0d_rst_n", c), 32'(ch_rst_n), 32'h0);
                chk($sformatf("c%0d_pin", c), 32'(ch_pin), 32'hfff);
                chk($sformatf("c%0d_sel_o", c), 32'(sel_o), 32'h2);
            end else if (c == 10) begin
                chk("c10_done", 32'(switch_done), 32'h1);
                chk("c10_clk_en", 32'(ch_clk_en), 32'h4);
                chk("c10_rst_n", 32'(ch_rst_n), 32'h4);
                chk("c10_pin", 32'(ch_pin), 32'(pin_exp(2, pin_in)));
                chk("c10_dat", 32'(ch_dat), 32'(dat_exp(2, dat_in)));
                chk("c10_busy", 32'(busy), 32'h0);
            end else if (c <= 16) begin
                chk($sformatf("c%0d_clk_en", c), 32'(ch_clk_en), 32'h0);
                chk($sformatf("c%0d_busy", c), 32'(busy), 32'h1);
                chk($sformatf("c%0d_sel_o", c), 32'(sel_o), 32'h2);
            end else if (c <= 19) begin
                chk($sformatf("c%0d_clk_en", c), 32'(ch_clk_en), 32'h8);
                chk($sformatf("c%0d_rst_n", c), 32'(ch_rst_n), 32'h0);
                chk($sformatf("c%0d_sel_o", c), 32'(sel_o), 32'h3);
            end else begin
                chk("c20_done", 32'(switch_done), 32'h1);
                chk("c20_clk_en", 32'(ch_clk_en), 32'h8);
                chk("c20_pin", 32'(ch_pin), 32'(pin_exp(3, pin_in)));
                chk("c20_busy", 32'(busy), 32'h0);
            end
            if (c == 4) sel_req = 2'd3;
            tick;
        end

        // Reset in the middle of a 3 -> 1 switch (during GAP).
        sel_req = 2'd1;
        tick;
        repeat (4) tick;
        rst = 1'b0; #1;
        chk("mrst_clk_en", 32'(ch_clk_en), 32'h0);
        chk("mrst_rst_n", 32'(ch_rst_n), 32'h0);
        chk("mrst_pin", 32'(ch_pin), 32'hfff);
        chk("mrst_dat", 32'(ch_dat), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h1);
        chk("mrst_sel_o", 32'(sel_o), 32'h0);
        sel_req = 2'd0;
        tick;
        rst = 1'b1; #1;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("marm%0d_clk_en", c), 32'(ch_clk_en), 32'h1);
            chk($sformatf("marm%0d_rst_n", c), 32'(ch_rst_n), 32'h0);
            tick;
        end
        chk("mact_done", 32'(switch_done), 32'h1);
        chk("mact_clk_en", 32'(ch_clk_en), 32'h1);
        chk("mact_sel_o", 32'(sel_o), 32'h0);

        // Out-of-range request on the three-channel instance.
        sel3 = 2'd3;
        tick;
        chk("err3_set", 32'(err3), 32'h1);
        chk("err3_busy", 32'(busy3), 32'h0);
        chk("err3_sel_o", 32'(sel_o3), 32'h0);
        chk("err3_clk_en", 32'(clk_en3), 32'h1);
        sel3 = 2'd0;
        tick; tick;
        chk("err3_sticky", 32'(err3), 32'h1);
        chk("err4_clear", 32'(sel_err), 32'h0);

        repeat (400) begin
            sel_req = 2'($urandom_range(0, 3));
            tick;
        end
        sel_req = 2'd1;
        begin
            int w = 0;
            while (!(sel_o == 2'd1 && !busy) && w < 40) begin
                tick;
                w++;
            end
        end
        chk("final_sel_o", 32'(sel_o), 32'h1);
        chk("final_busy", 32'(busy), 32'h0);
        chk("final_clk_en", 32'(ch_clk_en), 32'h2);
        tick;
        chk("inv_onehot", 32'(viol_onehot), 32'h0);
        chk("inv_gap", 32'(viol_gap), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
